sdram_arbiter: RTL and testbench

- Clocked arbiter sharing one Avalon-style SDRAM master port between two read requesters (video playback, audio playback) and one write requester (SD-card loader).
- Replaces manual switch-based steering with automatic request/grant sequencing.
- Writer has priority, bounded by a starvation guard. Readers alternate round-robin.
- Sits between the peripheral DMA engines and the SDRAM controller's Avalon slave.

---
 rtl/sdram_arbiter_if.sv | 45 ++++
 rtl/sdram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the SDRAM arbiter, its three DMA requesters and the
// SDRAM controller's Avalon slave. The master modport is the arbiter's view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr_out_toavl;
  logic              read_out_toavl;
  logic              write_out_toavl;
  logic [DATA_W-1:0] wrdata_out_toavl;
  logic [DATA_W-1:0] rddata_in_toavl;
  logic              ack_in_toavl;

  logic [ADDR_W-1:0] addr_in_1;
  logic [ADDR_W-1:0] addr_in_2;
  logic [ADDR_W-1:0] addr_in_write;
  logic              read_in_1;
  logic              read_in_2;
  logic              write_in;
  logic [DATA_W-1:0] wrdata_in;

  logic              ack_out_1;
  logic              ack_out_2;
  logic              ack_out_write;
  logic [DATA_W-1:0] readdata_out_1;
  logic [DATA_W-1:0] readdata_out_2;
  logic [1:0]        grant_out;
  logic              timeout_err;

  modport master (
    output addr_out_toavl, read_out_toavl, write_out_toavl, wrdata_out_toavl,
    input  rddata_in_toavl, ack_in_toavl,
    input  addr_in_1, addr_in_2, addr_in_write, read_in_1, read_in_2, write_in, wrdata_in,
    output ack_out_1, ack_out_2, ack_out_write, readdata_out_1, readdata_out_2,
    output grant_out, timeout_err
  );

  modport slave (
    input  addr_out_toavl, read_out_toavl, write_out_toavl, wrdata_out_toavl,
    output rddata_in_toavl, ack_in_toavl,
    output addr_in_1, addr_in_2, addr_in_write, read_in_1, read_in_2, write_in, wrdata_in,
    input  ack_out_1, ack_out_2, ack_out_write, readdata_out_1, readdata_out_2,
    input  grant_out, timeout_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-reader / one-writer arbiter for a single Avalon SDRAM master port.
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no grant, arbitrate this cycle
//   G_R1  | reader 1 (video) owns the bus
//   G_R2  | reader 2 (audio) owns the bus
//   G_W   | writer (SD loader) owns the bus
module sdram_arbiter #(
  parameter int ADDR_W         = 26,
  parameter int DATA_W         = 16,
  parameter int MAX_WR_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic             clk50,
  input logic             reset_n,
  sdram_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G_R1 = 2'd1,
    G_R2 = 2'd2,
    G_W  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_WR_STREAK);

  state_t            state;
  logic              last_rd2;
  logic [3:0]        wr_streak;
  logic              rd_pend;
  logic              req_live;
  logic              timed_out;

  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wrdata_sel;
  logic [DATA_W-1:0] rdd1;
  logic [DATA_W-1:0] rdd2;
  logic              rd_stb;
  logic              wr_stb;
  logic              ack1;
  logic              ack2;
  logic              ackw;

  assign rd_pend  = bus.read_in_1 | bus.read_in_2;
  assign req_live = rd_stb | wr_stb;

  // Bus steering is purely a function of the registered grant.
  always_comb begin
    addr_sel   = '0;
    wrdata_sel = '0;
    rdd1       = '0;
    rdd2       = '0;
    rd_stb     = 1'b0;
    wr_stb     = 1'b0;
    ack1       = 1'b0;
    ack2       = 1'b0;
    ackw       = 1'b0;
    case (state)
      G_R1: begin
        addr_sel = bus.addr_in_1;
        rd_stb   = bus.read_in_1;
        ack1     = bus.ack_in_toavl;
        rdd1     = bus.rddata_in_toavl;
      end
      G_R2: begin
        addr_sel = bus.addr_in_2;
        rd_stb   = bus.read_in_2;
        ack2     = bus.ack_in_toavl;
        rdd2     = bus.rddata_in_toavl;
      end
      G_W: begin
        addr_sel   = bus.addr_in_write;
        wr_stb     = bus.write_in;
        wrdata_sel = bus.wrdata_in;
        ackw       = bus.ack_in_toavl;
      end
      default: ;
    endcase
  end

  assign bus.addr_out_toavl   = addr_sel;
  assign bus.read_out_toavl   = rd_stb;
  assign bus.write_out_toavl  = wr_stb;
  assign bus.wrdata_out_toavl = wrdata_sel;
  assign bus.ack_out_1        = ack1;
  assign bus.ack_out_2        = ack2;
  assign bus.ack_out_write    = ackw;
  assign bus.readdata_out_1   = rdd1;
  assign bus.readdata_out_2   = rdd2;
  assign bus.grant_out        = state;

`ifdef ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LOAD = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] to_cnt;
  logic       to_err;

  // Down-counter reloaded while idle; terminal count means the grant has
  // gone TIMEOUT_CYCLES clocks without an ack.
  assign timed_out = (state != IDLE) && req_live && !bus.ack_in_toavl && (to_cnt == 10'd0);

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= TO_LOAD;
      to_err <= 1'b0;
    end else begin
      to_err <= timed_out;
      if (state == IDLE) to_cnt <= TO_LOAD;
      else if (!bus.ack_in_toavl && to_cnt != 10'd0) to_cnt <= to_cnt - 10'd1;
    end
  end

  assign bus.timeout_err = to_err;
`else
  assign timed_out       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_rd2  <= 1'b1;
      wr_streak <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_in && (!rd_pend || wr_streak < STREAK_MAX)) state <= G_W;
          else if (bus.read_in_1 && bus.read_in_2) state <= last_rd2 ? G_R1 : G_R2;
          else if (bus.read_in_1) state <= G_R1;
          else if (bus.read_in_2) state <= G_R2;
        end
        default: begin
          // A watchdog expiry retires the transfer exactly like an ack.
          if (bus.ack_in_toavl || timed_out) begin
            state <= IDLE;
            if (state == G_W) begin
              if (!rd_pend) wr_streak <= '0;
              else if (wr_streak != STREAK_MAX) wr_streak <= wr_streak + 4'd1;
            end else begin
              last_rd2  <= (state == G_R2);
              wr_streak <= '0;
            end
          end else if (!req_live) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: tests queue expected ack events, a
// negedge monitor pops and compares each one the DUT presents.
module tb_sdram_arbiter;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int MAX_WR = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1023;
`endif

  localparam logic [25:0] A1 = 26'h0001234;
  localparam logic [25:0] A2 = 26'h0ABCD56;
  localparam logic [25:0] AW = 26'h3000078;
  localparam logic [15:0] WD = 16'h1357;

  typedef struct packed {
    logic [1:0]  grant;
    logic [2:0]  acks;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [25:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wd;
  } ev_t;

  logic clk50 = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk50 = ~clk50;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WR_STREAK(MAX_WR), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_ack = 0;
  int          wr_seen = 0;
  bit          chk_no_wr = 0;
  ev_t         exp_q[$];

  logic        manual_ack = 1'b0;
  logic [15:0] manual_data = '0;
  logic        resp_en = 1'b0;
  logic        resp_ack = 1'b0;
  logic [15:0] resp_data = '0;
  int          resp_cnt = 0;

  assign bus.ack_in_toavl    = manual_ack | resp_ack;
  assign bus.rddata_in_toavl = manual_ack ? manual_data : resp_data;

  function automatic ev_t ev_rd(input logic [1:0] g, input logic [25:0] a, input logic [15:0] d);
    ev_t e = '0;
    e.grant = g;
    e.addr  = a;
    e.rd    = 1'b1;
    if (g == 2'd1) begin e.acks = 3'b001; e.rd1 = d; end
    else begin e.acks = 3'b010; e.rd2 = d; end
    return e;
  endfunction

  function automatic ev_t ev_wr(input logic [25:0] a, input logic [15:0] d);
    ev_t e = '0;
    e.grant = 2'd3;
    e.acks  = 3'b100;
    e.addr  = a;
    e.wr    = 1'b1;
    e.wd    = d;
    return e;
  endfunction

  // Controller model: ack on the third strobed cycle, data = {addr[7:0], C3}.
  initial begin
    forever begin
      @(posedge clk50); #1;
      if (resp_ack) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if (resp_en && (bus.read_out_toavl || bus.write_out_toavl)) begin
        resp_cnt++;
        if (resp_cnt == 3) begin
          resp_ack  = 1'b1;
          resp_data = {bus.addr_out_toavl[7:0], 8'hC3};
          resp_cnt  = 0;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  always @(negedge clk50) begin
    ev_t act, exp_e;
    if (bus.ack_out_1 || bus.ack_out_2 || bus.ack_out_write) begin
      act = '{grant: bus.grant_out,
              acks: {bus.ack_out_write, bus.ack_out_2, bus.ack_out_1},
              rd1: bus.readdata_out_1, rd2: bus.readdata_out_2,
              addr: bus.addr_out_toavl, rd: bus.read_out_toavl,
              wr: bus.write_out_toavl, wd: bus.wrdata_out_toavl};
      n_ack++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_ack #%0d: grant=%0d acks=%b with no event expected",
                 n_ack, act.grant, act.acks);
      end else begin
        exp_e = exp_q.pop_front();
        if (act !== exp_e) begin
          n_mis++;
          $display("FAIL ack_event #%0d: got grant=%0d acks=%b rd1=%h rd2=%h addr=%h rd=%b wr=%b wd=%h; want grant=%0d acks=%b rd1=%h rd2=%h addr=%h rd=%b wr=%b wd=%h",
                   n_ack, act.grant, act.acks, act.rd1, act.rd2, act.addr, act.rd, act.wr, act.wd,
                   exp_e.grant, exp_e.acks, exp_e.rd1, exp_e.rd2, exp_e.addr, exp_e.rd, exp_e.wr, exp_e.wd);
        end
      end
    end
    if (chk_no_wr && bus.write_out_toavl) wr_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic wait_grant(input logic [1:0] g, input int max, input string name);
    bit seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk50);
      if (bus.grant_out == g) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_mis++;
      $display("FAIL %s: grant_out=%0d, wanted %0d within %0d cycles", name, bus.grant_out, g, max);
    end
  endtask

  task automatic wait_acks(input int target, input int max, input string name);
    for (int i = 0; i < max && n_ack < target; i++) @(negedge clk50);
    n_cmp++;
    if (n_ack < target) begin
      n_mis++;
      $display("FAIL %s: saw %0d acks, wanted %0d within %0d cycles", name, n_ack, target, max);
    end
  endtask

  task automatic do_reset();
    reset_n           = 1'b0;
    resp_en           = 1'b0;
    manual_ack        = 1'b0;
    bus.read_in_1     = 1'b0;
    bus.read_in_2     = 1'b0;
    bus.write_in      = 1'b0;
    bus.addr_in_1     = A1;
    bus.addr_in_2     = A2;
    bus.addr_in_write = AW;
    bus.wrdata_in     = WD;
    repeat (2) @(posedge clk50);
    #1 reset_n = 1'b1;
    @(posedge clk50); #1;
  endtask

  logic [1:0] rr_seq [4]  = '{2'd1, 2'd2, 2'd1, 2'd2};
  logic [1:0] st_seq [10] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2};

  initial begin
    int base;
    int err_cnt;

    // Reset asserted in the middle of a write grant.
    do_reset();
    check("idle_after_reset", 32'(bus.grant_out), 32'd0);
    bus.write_in = 1'b1;
    wait_grant(2'd3, 5, "rst_pre_grant");
    @(posedge clk50); #1;
    reset_n = 1'b0;
    manual_ack = 1'b1;
    manual_data = 16'hFFFF;
    #2;
    check("rst_grant", 32'(bus.grant_out), 32'd0);
    check("rst_strobes_acks", {27'd0, bus.read_out_toavl, bus.write_out_toavl,
          bus.ack_out_1, bus.ack_out_2, bus.ack_out_write}, 32'd0);
    check("rst_addr", 32'(bus.addr_out_toavl), 32'd0);
    check("rst_data", {bus.readdata_out_1, bus.readdata_out_2}, 32'd0);
    check("rst_wrdata", 32'(bus.wrdata_out_toavl), 32'd0);
    manual_ack = 1'b0;
    @(posedge clk50); #1;
    reset_n = 1'b1;
    @(negedge clk50);
    check("rel_grant_c1", 32'(bus.grant_out), 32'd0);
    @(negedge clk50);
    check("rel_grant_c2", 32'(bus.grant_out), 32'd3);
    @(posedge clk50); #1;
    bus.write_in = 1'b0;
    repeat (2) @(posedge clk50);

    // Single read from reader 1 with a hand-driven ack.
    do_reset();
    exp_q.push_back(ev_rd(2'd1, A1, 16'hBEEF));
    bus.read_in_1 = 1'b1;
    wait_grant(2'd1, 5, "sr_grant");
    check("sr_addr", 32'(bus.addr_out_toavl), 32'h0001234);
    check("sr_strobes", {30'd0, bus.read_out_toavl, bus.write_out_toavl}, 32'd2);
    @(posedge clk50); #1;
    @(posedge clk50); #1;
    manual_data = 16'hBEEF;
    manual_ack  = 1'b1;
    @(posedge clk50); #1;
    manual_ack    = 1'b0;
    bus.read_in_1 = 1'b0;
    @(negedge clk50);
    check("sr_idle_after_ack", 32'(bus.grant_out), 32'd0);
    check("sr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Round-robin between the two readers.
    do_reset();
    base = n_ack;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(ev_rd(rr_seq[i], (rr_seq[i] == 2'd1) ? A1 : A2,
                            (rr_seq[i] == 2'd1) ? 16'h34C3 : 16'h56C3));
    wr_seen   = 0;
    chk_no_wr = 1;
    resp_en   = 1'b1;
    bus.read_in_1 = 1'b1;
    bus.read_in_2 = 1'b1;
    wait_acks(base + 4, 60, "rr_acks");
    @(posedge clk50); #1;
    bus.read_in_1 = 1'b0;
    bus.read_in_2 = 1'b0;
    repeat (3) @(posedge clk50);
    chk_no_wr = 0;
    check("rr_no_write_strobe", 32'(wr_seen), 32'd0);
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Write priority bounded by the streak guard.
    do_reset();
    base = n_ack;
    for (int i = 0; i < 10; i++)
      exp_q.push_back((st_seq[i] == 2'd3) ? ev_wr(AW, WD) : ev_rd(2'd2, A2, 16'h56C3));
    resp_en      = 1'b1;
    bus.write_in  = 1'b1;
    bus.read_in_2 = 1'b1;
    wait_acks(base + 10, 150, "starve_acks");
    @(posedge clk50); #1;
    bus.write_in  = 1'b0;
    bus.read_in_2 = 1'b0;
    repeat (3) @(posedge clk50);
    check("starve_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort before ack; last_rd must still favour reader 1 afterwards.
    do_reset();
    bus.read_in_1 = 1'b1;
    wait_grant(2'd1, 5, "ab_grant");
    @(posedge clk50); #1;
    bus.read_in_1 = 1'b0;
    @(negedge clk50);
    check("ab_strobe_drops", 32'(bus.read_out_toavl), 32'd0);
    @(negedge clk50);
    check("ab_idle", 32'(bus.grant_out), 32'd0);
    repeat (2) @(posedge clk50);
    #1;
    base = n_ack;
    exp_q.push_back(ev_rd(2'd1, A1, 16'h34C3));
    resp_en = 1'b1;
    bus.read_in_1 = 1'b1;
    bus.read_in_2 = 1'b1;
    wait_acks(base + 1, 20, "ab_followup_ack");
    @(posedge clk50); #1;
    bus.read_in_1 = 1'b0;
    bus.read_in_2 = 1'b0;
    resp_en = 1'b0;
    repeat (3) @(posedge clk50);
    check("ab_queue_empty", 32'(exp_q.size()), 32'd0);

    // Unacknowledged write: watchdog expiry, or indefinite hold without it.
    do_reset();
    bus.write_in = 1'b1;
    wait_grant(2'd3, 5, "to_grant");
`ifdef ARB_TIMEOUT_EN
    err_cnt = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk50);
      if (bus.timeout_err || bus.grant_out != 2'd3) err_cnt++;
    end
    check("to_quiet_before_limit", 32'(err_cnt), 32'd0);
    @(negedge clk50);
    check("to_err_pulse", 32'(bus.timeout_err), 32'd1);
    check("to_grant_idle", 32'(bus.grant_out), 32'd0);
    @(negedge clk50);
    check("to_err_one_cycle", 32'(bus.timeout_err), 32'd0);
`else
    err_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50);
      if (bus.timeout_err) err_cnt++;
    end
    check("to_err_tied_low", 32'(err_cnt), 32'd0);
    check("to_grant_held", 32'(bus.grant_out), 32'd3);
`endif
    @(posedge clk50); #1;
    bus.write_in = 1'b0;
    repeat (3) @(posedge clk50);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
